// File: rtl/note_lane_sequencer.sv
// note_lane_sequencer: one note-highway lane shifted per frame tick and
// redrawn as erase/draw requests to a fixed-latency 4x4 square drawer.
// Ports: clk, reset (async, active-high), frame_tick, note_in, note_colour
// in; go, sq_x, sq_y, colour, draw to the drawer; busy, frame_done,
// miss_pulse, overrun, lane status out.
// Macro NOTE_HIT_EN adds input hit and hit_ok/hit_bad pulse outputs.
module note_lane_sequencer #(
   parameter int SLOTS       = 16,
   parameter int X_BASE      = 32,
   parameter int LANE_Y      = 60,
   parameter int DRAW_CYCLES = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic             note_in,
   input  logic [2:0]       note_colour,
`ifdef NOTE_HIT_EN
   input  logic             hit,
   output logic             hit_ok,
   output logic             hit_bad,
`endif
   output logic             go,
   output logic [7:0]       sq_x,
   output logic [6:0]       sq_y,
   output logic [2:0]       colour,
   output logic             draw,
   output logic             busy,
   output logic             frame_done,
   output logic             miss_pulse,
   output logic             overrun,
   output logic [SLOTS-1:0] lane
);

   localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int CW = (DRAW_CYCLES > 2) ? $clog2(DRAW_CYCLES) : 1;
   localparam logic [IW-1:0] LAST  = IW'(SLOTS - 1);
   localparam logic [CW-1:0] WLAST = CW'(DRAW_CYCLES - 2);
   localparam logic [7:0]    XB    = 8'(X_BASE);

   typedef enum logic [3:0] {
      IDLE,
      ERASE_SCAN,
      ERASE_ISSUE,
      ERASE_WAIT,
      SHIFT,
      DRAW_SCAN,
      DRAW_ISSUE,
      DRAW_WAIT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [SLOTS-1:0] lane_q, lane_d;
   logic [SLOTS-1:0] drawn_q, drawn_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    wait_q, wait_d;
   logic             pend_q, pend_d;
   logic             pnote_q, pnote_d;
   logic             note_q, note_d;
   logic             ovr_q, ovr_d;
   logic [7:0]       sq_x_q, sq_x_d;
   logic [2:0]       colour_q, colour_d;
   logic             draw_q, draw_d;
`ifdef NOTE_HIT_EN
   logic             hit_ok_q, hit_ok_d;
   logic             hit_bad_q, hit_bad_d;
`endif

   logic             in_draw;
   logic [IW-1:0]    idx_inc;
   logic [7:0]       x_cur;
   logic [7:0]       x_nxt;
   logic             mask_cur;
   logic             mask_nxt;
   logic [2:0]       req_colour;
   state_t           issue_st;
   state_t           wait_st;
   state_t           scan_st;
   state_t           end_st;

   // Erase and draw passes share one walker; the pass picks the mask.
   assign in_draw = (state_q == DRAW_SCAN) || (state_q == DRAW_ISSUE) ||
                    (state_q == DRAW_WAIT);
   assign idx_inc = idx_q + IW'(1);
   assign x_cur   = XB + (8'(idx_q) << 2);
   assign x_nxt   = XB + (8'(idx_inc) << 2);
   assign mask_cur = in_draw ? lane_q[idx_q] : drawn_q[idx_q];
   assign mask_nxt = in_draw ? lane_q[idx_inc] : drawn_q[idx_inc];
   assign req_colour = in_draw ? note_colour : 3'b000;
   assign issue_st = in_draw ? DRAW_ISSUE : ERASE_ISSUE;
   assign wait_st  = in_draw ? DRAW_WAIT : ERASE_WAIT;
   assign scan_st  = in_draw ? DRAW_SCAN : ERASE_SCAN;
   assign end_st   = in_draw ? DONE : SHIFT;

   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      drawn_d  = drawn_q;
      idx_d    = idx_q;
      wait_d   = wait_q;
      pend_d   = pend_q;
      pnote_d  = pnote_q;
      note_d   = note_q;
      ovr_d    = ovr_q;
      sq_x_d   = sq_x_q;
      colour_d = colour_q;
      draw_d   = draw_q;
`ifdef NOTE_HIT_EN
      hit_ok_d  = 1'b0;
      hit_bad_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (frame_tick || pend_q) begin
               note_d  = pend_q ? pnote_q : note_in;
               pend_d  = 1'b0;
               idx_d   = '0;
               state_d = ERASE_SCAN;
            end
         end
         ERASE_SCAN, DRAW_SCAN: begin
            if (mask_cur) begin
               state_d  = issue_st;
               sq_x_d   = x_cur;
               draw_d   = in_draw;
               colour_d = req_colour;
            end else if (idx_q == LAST) begin
               state_d = end_st;
            end else begin
               idx_d = idx_inc;
            end
         end
         ERASE_ISSUE, DRAW_ISSUE: begin
            wait_d  = '0;
            state_d = wait_st;
         end
         ERASE_WAIT, DRAW_WAIT: begin
            if (wait_q == WLAST) begin
               if (idx_q == LAST) begin
                  state_d = end_st;
               end else begin
                  idx_d = idx_inc;
                  // An occupied neighbour skips its scan cycle so
                  // back-to-back requests stay DRAW_CYCLES apart.
                  if (mask_nxt) begin
                     state_d  = issue_st;
                     sq_x_d   = x_nxt;
                     draw_d   = in_draw;
                     colour_d = req_colour;
                  end else begin
                     state_d = scan_st;
                  end
               end
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         SHIFT: begin
            lane_d  = {note_q, lane_q[SLOTS-1:1]};
            idx_d   = '0;
            state_d = DRAW_SCAN;
         end
         DONE: begin
            drawn_d = lane_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A tick the IDLE branch cannot take is queued once; a second
      // queued tick loses its note and flags overrun.
      if (frame_tick && ((state_q != IDLE) || pend_q)) begin
         if (pend_q) begin
            ovr_d = 1'b1;
         end else begin
            pend_d  = 1'b1;
            pnote_d = note_in;
         end
      end

`ifdef NOTE_HIT_EN
      if (hit && (state_q == IDLE)) begin
         if (lane_q[0]) begin
            lane_d[0] = 1'b0;
            hit_ok_d  = 1'b1;
         end else if (lane_q[1]) begin
            lane_d[1] = 1'b0;
            hit_ok_d  = 1'b1;
         end else begin
            hit_bad_d = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         lane_q   <= '0;
         drawn_q  <= '0;
         idx_q    <= '0;
         wait_q   <= '0;
         pend_q   <= 1'b0;
         pnote_q  <= 1'b0;
         note_q   <= 1'b0;
         ovr_q    <= 1'b0;
         sq_x_q   <= '0;
         colour_q <= '0;
         draw_q   <= 1'b0;
`ifdef NOTE_HIT_EN
         hit_ok_q  <= 1'b0;
         hit_bad_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         drawn_q  <= drawn_d;
         idx_q    <= idx_d;
         wait_q   <= wait_d;
         pend_q   <= pend_d;
         pnote_q  <= pnote_d;
         note_q   <= note_d;
         ovr_q    <= ovr_d;
         sq_x_q   <= sq_x_d;
         colour_q <= colour_d;
         draw_q   <= draw_d;
`ifdef NOTE_HIT_EN
         hit_ok_q  <= hit_ok_d;
         hit_bad_q <= hit_bad_d;
`endif
      end
   end

   assign go         = (state_q == ERASE_ISSUE) || (state_q == DRAW_ISSUE);
   assign sq_x       = sq_x_q;
   assign sq_y       = 7'(LANE_Y);
   assign colour     = colour_q;
   assign draw       = draw_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == DONE);
   assign miss_pulse = (state_q == SHIFT) && lane_q[0];
   assign overrun    = ovr_q;
   assign lane       = lane_q;
`ifdef NOTE_HIT_EN
   assign hit_ok  = hit_ok_q;
   assign hit_bad = hit_bad_q;
`endif

endmodule

// File: tb/tb_note_lane_sequencer.sv
// tb_note_lane_sequencer: frame-level reference model of the lane
// sequencer, checking every request, frame_done and miss cycle.
module tb_note_lane_sequencer;

   localparam int SLOTS  = 16;
   localparam int X_BASE = 32;
   localparam int LANE_Y = 60;
   localparam int D      = 17;

   typedef struct packed {
      logic [31:0] cyc;
      logic        draw;
      logic [7:0]  x;
      logic [2:0]  col;
   } req_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        frame_tick = 1'b0;
   logic        note_in = 1'b0;
   logic [2:0]  note_colour = 3'd0;
   logic        go, draw, busy, frame_done, miss_pulse, overrun;
   logic [7:0]  sq_x;
   logic [6:0]  sq_y;
   logic [2:0]  colour;
   logic [15:0] lane;
`ifdef NOTE_HIT_EN
   logic        hit = 1'b0;
   logic        hit_ok, hit_bad;
`endif

   note_lane_sequencer dut (
      .clk(clk),
      .reset(reset),
      .frame_tick(frame_tick),
      .note_in(note_in),
      .note_colour(note_colour),
`ifdef NOTE_HIT_EN
      .hit(hit),
      .hit_ok(hit_ok),
      .hit_bad(hit_bad),
`endif
      .go(go),
      .sq_x(sq_x),
      .sq_y(sq_y),
      .colour(colour),
      .draw(draw),
      .busy(busy),
      .frame_done(frame_done),
      .miss_pulse(miss_pulse),
      .overrun(overrun),
      .lane(lane)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   req_t reqs[$];
   req_t exp_q[$];
   int dones[$];
   int exp_done[$];
   int misses[$];
   int exp_miss[$];
   int go_twice = 0;
   int x_moved = 0;
   int y_bad = 0;
   logic [15:0] m_lane = '0;
   logic [15:0] m_drawn = '0;
   logic m_ovr = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin : mon
      logic prev_go;
      logic [7:0] hold_x;
      int hold_n;
      prev_go = 1'b0;
      hold_x = '0;
      hold_n = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_go = 1'b0;
            hold_n = 0;
         end else begin
            if (hold_n > 0) begin
               if (sq_x !== hold_x) x_moved++;
               hold_n--;
            end
            if (go) begin
               reqs.push_back('{32'(cyc), draw, sq_x, colour});
               hold_x = sq_x;
               hold_n = D - 1;
               if (prev_go) go_twice++;
            end
            if (sq_y !== 7'(LANE_Y)) y_bad++;
            if (frame_done) dones.push_back(cyc);
            if (miss_pulse) misses.push_back(cyc);
            prev_go = go;
         end
      end
   end

   // One pass over a mask starting at cycle t0: empty slots cost one
   // cycle, each request costs D, and a request not directly following
   // another is first found by a one-cycle scan. Returns the next cycle.
   function automatic int walk(logic [15:0] m, int t0, logic dr,
                               logic [2:0] col);
      int t;
      t = t0;
      for (int i = 0; i < SLOTS; i++) begin
         if (m[i]) begin
            if (i == 0 || !m[i-1]) t++;
            exp_q.push_back('{32'(t), dr, 8'(X_BASE + 4 * i), col});
            t += D;
         end else begin
            t++;
         end
      end
      return t;
   endfunction

   function automatic int model_frame(logic n, int s, logic [2:0] col);
      int t;
      t = walk(m_drawn, s, 1'b0, 3'b000);
      if (m_lane[0]) exp_miss.push_back(t);
      m_lane = {n, m_lane[15:1]};
      t = walk(m_lane, t + 1, 1'b1, col);
      exp_done.push_back(t);
      m_drawn = m_lane;
      return t;
   endfunction

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 3000) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (busy) begin
         fails++;
         $display("FAIL idle_wait busy=%b required 0", busy);
      end
   endtask

   task automatic run_frame(input logic n1, input int extra,
                            input logic n2, input logic n3,
                            input logic [2:0] col);
      int c0;
      int f;
      wait_idle();
      note_colour = col;
      reqs.delete();
      dones.delete();
      misses.delete();
      exp_q.delete();
      exp_done.delete();
      exp_miss.delete();
      go_twice = 0;
      x_moved = 0;
      y_bad = 0;
      c0 = cyc;
      frame_tick = 1'b1;
      note_in = n1;
      @(negedge clk);
      frame_tick = 1'b0;
      note_in = 1'b0;
      f = model_frame(n1, c0 + 1, col);
      if (extra >= 1) begin
         repeat (3) @(negedge clk);
         frame_tick = 1'b1;
         note_in = n2;
         @(negedge clk);
         frame_tick = 1'b0;
         note_in = 1'b0;
         if (extra >= 2) begin
            repeat (2) @(negedge clk);
            frame_tick = 1'b1;
            note_in = n3;
            @(negedge clk);
            frame_tick = 1'b0;
            note_in = 1'b0;
            m_ovr = 1'b1;
         end
         void'(model_frame(n2, f + 2, col));
      end
      for (int k = 0; k < 3000 && dones.size() < exp_done.size(); k++)
         @(negedge clk);
      tests++;
      if (dones.size() != exp_done.size()) begin
         fails++;
         $display("FAIL frame_done_count got %0d required %0d",
                  dones.size(), exp_done.size());
      end
      for (int i = 0; i < dones.size() && i < exp_done.size(); i++) begin
         tests++;
         if (dones[i] != exp_done[i]) begin
            fails++;
            $display("FAIL frame_done_cycle[%0d] got %0d required %0d",
                     i, dones[i], exp_done[i]);
         end
      end
      tests++;
      if (reqs.size() != exp_q.size()) begin
         fails++;
         $display("FAIL req_count got %0d required %0d",
                  reqs.size(), exp_q.size());
      end
      for (int i = 0; i < reqs.size() && i < exp_q.size(); i++) begin
         tests++;
         if (reqs[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL req[%0d] got cyc=%0d draw=%b x=%0d col=%0d required cyc=%0d draw=%b x=%0d col=%0d",
                     i, reqs[i].cyc, reqs[i].draw, reqs[i].x, reqs[i].col,
                     exp_q[i].cyc, exp_q[i].draw, exp_q[i].x, exp_q[i].col);
         end
      end
      tests++;
      if (misses.size() != exp_miss.size() ||
          (misses.size() > 0 && misses[0] != exp_miss[0])) begin
         fails++;
         $display("FAIL miss_pulse got count=%0d required count=%0d",
                  misses.size(), exp_miss.size());
      end
      tests++;
      if (lane !== m_lane) begin
         fails++;
         $display("FAIL lane got %h required %h", lane, m_lane);
      end
      tests++;
      if (overrun !== m_ovr) begin
         fails++;
         $display("FAIL overrun got %b required %b", overrun, m_ovr);
      end
      tests++;
      if (go_twice != 0 || x_moved != 0 || y_bad != 0) begin
         fails++;
         $display("FAIL go_shape got twice=%0d xmove=%0d ybad=%0d required 0 0 0",
                  go_twice, x_moved, y_bad);
      end
   endtask

   task automatic test_reset();
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if ({go, draw, busy, frame_done, miss_pulse, overrun} !== 6'b0) begin
         fails++;
         $display("FAIL reset_flags got %b required 000000",
                  {go, draw, busy, frame_done, miss_pulse, overrun});
      end
      tests++;
      if (sq_x !== 8'd0 || colour !== 3'd0 || lane !== 16'h0) begin
         fails++;
         $display("FAIL reset_data got x=%0d col=%0d lane=%h required 0 0 0",
                  sq_x, colour, lane);
      end
      tests++;
      if (sq_y !== 7'd60) begin
         fails++;
         $display("FAIL reset_sq_y got %0d required 60", sq_y);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || go !== 1'b0) begin
         fails++;
         $display("FAIL post_reset got busy=%b go=%b required 0 0", busy, go);
      end
   endtask

   task automatic test_first_note();
      run_frame(1'b1, 0, 1'b0, 1'b0, 3'd5);
      tests++;
      if (lane !== 16'h8000) begin
         fails++;
         $display("FAIL first_lane got %h required 8000", lane);
      end
      tests++;
      if (reqs.size() != 1 || reqs[0].draw !== 1'b1 ||
          reqs[0].x !== 8'd92 || reqs[0].col !== 3'd5) begin
         fails++;
         $display("FAIL first_req got n=%0d draw=%b x=%0d col=%0d required 1 1 92 5",
                  reqs.size(), reqs[0].draw, reqs[0].x, reqs[0].col);
      end
      tests++;
      if (dones.size() != 1 || dones[0] - int'(reqs[0].cyc) != D) begin
         fails++;
         $display("FAIL first_done_gap got %0d required %0d",
                  dones[0] - int'(reqs[0].cyc), D);
      end
   endtask

   task automatic test_second_note();
      run_frame(1'b0, 0, 1'b0, 1'b0, 3'd2);
      tests++;
      if (lane !== 16'h4000) begin
         fails++;
         $display("FAIL second_lane got %h required 4000", lane);
      end
      tests++;
      if (reqs.size() != 2 || reqs[0].draw !== 1'b0 ||
          reqs[0].x !== 8'd92 || reqs[0].col !== 3'd0 ||
          reqs[1].draw !== 1'b1 || reqs[1].x !== 8'd88 ||
          reqs[1].col !== 3'd2) begin
         fails++;
         $display("FAIL second_reqs got n=%0d x0=%0d x1=%0d required 2 92 88",
                  reqs.size(), reqs[0].x, reqs[1].x);
      end
   endtask

   task automatic test_miss();
      for (int i = 0; i < 14; i++)
         run_frame(1'b0, 0, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
      tests++;
      if (lane !== 16'h0001) begin
         fails++;
         $display("FAIL miss_setup_lane got %h required 0001", lane);
      end
      run_frame(1'b0, 0, 1'b0, 1'b0, 3'd7);
      tests++;
      if (misses.size() != 1 || lane !== 16'h0) begin
         fails++;
         $display("FAIL miss_out got misses=%0d lane=%h required 1 0000",
                  misses.size(), lane);
      end
      tests++;
      if (reqs.size() != 1 || reqs[0].draw !== 1'b0 ||
          reqs[0].x !== 8'd32) begin
         fails++;
         $display("FAIL miss_erase got n=%0d x=%0d required 1 32",
                  reqs.size(), reqs[0].x);
      end
   endtask

   task automatic test_back_to_back();
      int pairs;
      run_frame(1'b1, 0, 1'b0, 1'b0, 3'd1);
      run_frame(1'b1, 0, 1'b0, 1'b0, 3'd3);
      run_frame(1'b1, 0, 1'b0, 1'b0, 3'd4);
      pairs = 0;
      for (int i = 1; i < reqs.size(); i++) begin
         if (reqs[i].draw == reqs[i-1].draw) begin
            pairs++;
            tests++;
            if (int'(reqs[i].cyc) - int'(reqs[i-1].cyc) != D) begin
               fails++;
               $display("FAIL b2b_gap[%0d] got %0d required %0d", i,
                        int'(reqs[i].cyc) - int'(reqs[i-1].cyc), D);
            end
         end
      end
      tests++;
      if (pairs != 3) begin
         fails++;
         $display("FAIL b2b_pairs got %0d required 3", pairs);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++)
         run_frame(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 1 : 0,
                   1'($urandom_range(0, 1)), 1'b0,
                   3'($urandom_range(0, 7)));
   endtask

   task automatic test_overrun();
      run_frame(1'b1, 2, 1'b0, 1'b1, 3'd6);
      tests++;
      if (overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_set got %b required 1", overrun);
      end
      run_frame(1'b0, 0, 1'b0, 1'b0, 3'd6);
      tests++;
      if (overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_sticky got %b required 1", overrun);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      run_frame(1'b1, 0, 1'b0, 1'b0, 3'd2);
      for (int i = 0; i < 14; i++)
         run_frame(1'b0, 0, 1'b0, 1'b0, 3'd2);
      run_frame(1'b1, 0, 1'b0, 1'b0, 3'd2);
      tests++;
      if (lane !== 16'h8001) begin
         fails++;
         $display("FAIL mid_setup_lane got %h required 8001", lane);
      end
      wait_idle();
      frame_tick = 1'b1;
      note_in = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      note_in = 1'b0;
      k = 0;
      while (!go && k < 200) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (go !== 1'b1) begin
         fails++;
         $display("FAIL mid_go_seen got %b required 1", go);
      end
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if ({go, draw, busy, frame_done, miss_pulse, overrun} !== 6'b0 ||
          sq_x !== 8'd0 || colour !== 3'd0 || lane !== 16'h0 ||
          sq_y !== 7'd60) begin
         fails++;
         $display("FAIL mid_reset got flags=%b x=%0d col=%0d lane=%h y=%0d required 000000 0 0 0000 60",
                  {go, draw, busy, frame_done, miss_pulse, overrun},
                  sq_x, colour, lane, sq_y);
      end
      @(negedge clk);
      reset = 1'b0;
      reqs.delete();
      m_lane = '0;
      m_drawn = '0;
      m_ovr = 1'b0;
      repeat (60) @(negedge clk);
      tests++;
      if (reqs.size() != 0 || lane !== 16'h0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL after_reset got gos=%0d lane=%h busy=%b required 0 0000 0",
                  reqs.size(), lane, busy);
      end
   endtask

`ifdef NOTE_HIT_EN
   task automatic test_hit();
      run_frame(1'b1, 0, 1'b0, 1'b0, 3'd3);
      for (int i = 0; i < 14; i++)
         run_frame(1'b0, 0, 1'b0, 1'b0, 3'd3);
      tests++;
      if (lane !== 16'h0002) begin
         fails++;
         $display("FAIL hit_setup_lane got %h required 0002", lane);
      end
      wait_idle();
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
      m_lane[1] = 1'b0;
      tests++;
      if (hit_ok !== 1'b1 || hit_bad !== 1'b0 || lane !== 16'h0) begin
         fails++;
         $display("FAIL hit_ok got ok=%b bad=%b lane=%h required 1 0 0000",
                  hit_ok, hit_bad, lane);
      end
      run_frame(1'b0, 0, 1'b0, 1'b0, 3'd3);
      tests++;
      if (reqs.size() != 1 || reqs[0].draw !== 1'b0 ||
          reqs[0].x !== 8'd36) begin
         fails++;
         $display("FAIL hit_erase got n=%0d x=%0d required 1 36",
                  reqs.size(), reqs[0].x);
      end
      wait_idle();
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
      tests++;
      if (hit_bad !== 1'b1 || hit_ok !== 1'b0) begin
         fails++;
         $display("FAIL hit_bad got ok=%b bad=%b required 0 1",
                  hit_ok, hit_bad);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_first_note();
      test_second_note();
      test_miss();
      test_back_to_back();
      test_random();
      test_overrun();
      test_reset_mid();
`ifdef NOTE_HIT_EN
      test_hit();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
